// File: rtl/a2b_pkg.sv
// a2b_pkg: shared types and constants for the ASCII decimal parser.
//   a2b_state_t : parser FSM states
//   a2b_class_t : character classes produced by ascii_char_class
//   ASCII_*     : character codes recognised by the parser
package a2b_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INT,
    DEC,
    ERR,
    DONE
  } a2b_state_t;

  typedef enum logic [2:0] {
    DIGIT,
    POINT,
    TERM,
    SPACE,
    ILLEGAL
  } a2b_class_t;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_POINT = 8'h2E;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // Largest two-digit decimal part.
  localparam int DEC_MAX = 99;

endpackage

// File: rtl/ascii_char_class.sv
// ascii_char_class: combinational character classifier.
//   in_byte : ASCII character
//   cls     : DIGIT / POINT / TERM (LF or CR) / SPACE / ILLEGAL
//   digit   : numeric value of a digit character, 0 otherwise
module ascii_char_class
  import a2b_pkg::*;
(
  input  logic [7:0] in_byte,
  output a2b_class_t cls,
  output logic [3:0] digit
);

  always_comb begin
    cls   = ILLEGAL;
    digit = 4'd0;
    if (in_byte >= ASCII_0 && in_byte <= ASCII_9) begin
      cls   = DIGIT;
      digit = in_byte[3:0];
    end else if (in_byte == ASCII_POINT) begin
      cls = POINT;
    end else if (in_byte == ASCII_LF || in_byte == ASCII_CR) begin
      cls = TERM;
    end else if (in_byte == ASCII_SPACE) begin
      cls = SPACE;
    end
  end

endmodule

// File: rtl/ascii_to_binary.sv
// ascii_to_binary: byte-serial ASCII decimal parser ("4095.99\n" -> 4095, 99).
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_byte     : input character stream, accepted when in_ready
//   int_part/dec_part    : parsed integer and two-digit decimal part
//   out_err              : parse error flag (int/dec forced to 0)
//   out_valid/out_ready  : result handshake, result held until accepted
// Optional build macro A2B_ROUND_EN: round on the third decimal digit.
//
// state | meaning
// IDLE  | waiting for the first character of a number
// INT   | collecting integer digits
// DEC   | collecting decimal digits
// ERR   | bad input seen, discarding until a terminator
// DONE  | result presented, waiting for out_ready
module ascii_to_binary
  import a2b_pkg::*;
#(
  parameter int INT_W      = 12,
  parameter int DEC_W      = 8,
  parameter int INT_DIGITS = 4,
  parameter int DEC_DIGITS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_byte,
  output logic             in_ready,
  output logic [INT_W-1:0] int_part,
  output logic [DEC_W-1:0] dec_part,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int ICW = $clog2(INT_DIGITS + 1);
  localparam int DCW = $clog2(DEC_DIGITS + 2);
  localparam logic [INT_W+3:0] WIDE_MAX = {4'b0000, {INT_W{1'b1}}};

  a2b_state_t       state, next_state;
  a2b_class_t       cls;
  logic [3:0]       digit;
  logic [INT_W-1:0] acc;
  logic [ICW-1:0]   int_cnt;
  logic [DEC_W-1:0] frac;
  logic [DCW-1:0]   dec_cnt;
  logic             err_flag;
  logic             take;
  logic [INT_W+3:0] acc_wide;
  logic             int_ovf;
  logic [DEC_W-1:0] d_x10;
  logic             bare;
  logic [INT_W-1:0] res_int;
  logic [DEC_W-1:0] res_dec;
  logic             res_err;
`ifdef A2B_ROUND_EN
  logic [3:0]       rnd_digit;
`endif

  ascii_char_class u_class (
    .in_byte (in_byte),
    .cls     (cls),
    .digit   (digit)
  );

  assign take     = in_valid && in_ready;
  // acc*10 + d in a widened word so overflow is seen before truncation.
  assign acc_wide = ({4'b0000, acc} << 3) + ({4'b0000, acc} << 1) + {{INT_W{1'b0}}, digit};
  assign int_ovf  = (acc_wide > WIDE_MAX) || (int_cnt == ICW'(INT_DIGITS));
  assign d_x10    = DEC_W'({digit, 3'b000}) + DEC_W'({digit, 1'b0});
  assign bare     = (int_cnt == '0) && (dec_cnt == '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (take) begin
        case (cls)
          DIGIT:   next_state = INT;
          POINT:   next_state = DEC;
          ILLEGAL: next_state = ERR;
          default: next_state = IDLE;
        endcase
      end
      INT: if (take) begin
        case (cls)
          DIGIT:   next_state = int_ovf ? ERR : INT;
          POINT:   next_state = DEC;
          TERM:    next_state = DONE;
          default: next_state = ERR;
        endcase
      end
      // A bare "." reaches DONE directly with err_flag set.
      DEC: if (take) begin
        case (cls)
          DIGIT:   next_state = DEC;
          TERM:    next_state = DONE;
          default: next_state = ERR;
        endcase
      end
      ERR:  if (take && cls == TERM) next_state = DONE;
      DONE: if (out_valid && out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic: handshake and the result to be registered on DONE entry
  always_comb begin
    in_ready = (state != DONE);
    res_err  = err_flag;
    res_int  = acc;
    res_dec  = frac;
`ifdef A2B_ROUND_EN
    if (!err_flag && rnd_digit >= 4'd5) begin
      if (frac == DEC_W'(DEC_MAX)) begin
        res_dec = '0;
        if (acc == {INT_W{1'b1}}) res_err = 1'b1;
        else                      res_int = acc + INT_W'(1);
      end else begin
        res_dec = frac + DEC_W'(1);
      end
    end
`endif
    if (res_err) begin
      res_int = '0;
      res_dec = '0;
    end
  end

  // Accumulators
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      int_cnt   <= '0;
      frac      <= '0;
      dec_cnt   <= '0;
      err_flag  <= 1'b0;
`ifdef A2B_ROUND_EN
      rnd_digit <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          acc       <= '0;
          int_cnt   <= '0;
          frac      <= '0;
          dec_cnt   <= '0;
          err_flag  <= (next_state == ERR);
`ifdef A2B_ROUND_EN
          rnd_digit <= '0;
`endif
          if (take && cls == DIGIT) begin
            acc     <= INT_W'(digit);
            int_cnt <= ICW'(1);
          end
        end
        INT: if (take) begin
          if (next_state == ERR) begin
            err_flag <= 1'b1;
          end else if (cls == DIGIT) begin
            acc     <= acc_wide[INT_W-1:0];
            int_cnt <= int_cnt + ICW'(1);
          end
        end
        DEC: if (take) begin
          if (cls == DIGIT) begin
            if (dec_cnt == DCW'(0))      frac <= d_x10;
            else if (dec_cnt == DCW'(1)) frac <= frac + DEC_W'(digit);
`ifdef A2B_ROUND_EN
            else if (dec_cnt == DCW'(DEC_DIGITS)) rnd_digit <= digit;
`endif
            if (dec_cnt != DCW'(DEC_DIGITS + 1)) dec_cnt <= dec_cnt + DCW'(1);
          end else if (cls == TERM) begin
            if (bare) err_flag <= 1'b1;
          end else begin
            err_flag <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Result registers: loaded on the first DONE cycle, held until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      int_part  <= '0;
      dec_part  <= '0;
      out_err   <= 1'b0;
    end else if (state == DONE && !out_valid) begin
      out_valid <= 1'b1;
      int_part  <= res_int;
      dec_part  <= res_dec;
      out_err   <= res_err;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ascii_to_binary.sv
module tb_ascii_to_binary;

  localparam int INT_W = 12;
  localparam int DEC_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [7:0]       in_byte;
  logic             in_ready;
  logic [INT_W-1:0] int_part;
  logic [DEC_W-1:0] dec_part;
  logic             out_err;
  logic             out_valid;
  logic             out_ready;

  always #5 clk = ~clk;

  ascii_to_binary dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_byte   (in_byte),
    .in_ready  (in_ready),
    .int_part  (int_part),
    .dec_part  (dec_part),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    string s;
    int    ei;
    int    ed;
    bit    ee;
  } vec_t;

  typedef struct {
    string name;
    int    ei;
    int    ed;
    bit    ee;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input string s, input int ei, input int ed, input bit ee);
    vec_t v;
    v.s = s; v.ei = ei; v.ed = ed; v.ee = ee;
    vecs.push_back(v);
  endtask

  task automatic push_exp(input string name, input int ei, input int ed, input bit ee);
    exp_t e;
    e.name = name; e.ei = ei; e.ed = ed; e.ee = ee;
    exp_q.push_back(e);
  endtask

  // Scoreboard side: compare every accepted result against the queue head.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got int=%0d dec=%0d err=%0d with nothing expected",
                   int_part, dec_part, out_err);
        end else begin
          e = exp_q.pop_front();
          chk({e.name, "_int"}, int'(int_part), e.ei);
          chk({e.name, "_dec"}, int'(dec_part), e.ed);
          chk({e.name, "_err"}, int'(out_err), int'(e.ee));
        end
      end
    end
  endtask

  // Drive one byte; in_ready sampled in the cycle before each edge.
  task automatic send_byte(input logic [7:0] b);
    logic rdy;
    in_valid = 1'b1;
    in_byte  = b;
    for (int t = 0; t < 100; t++) begin
      rdy = in_ready;
      @(posedge clk); #2;
      if (rdy) begin
        in_valid = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: byte 0x%02h not accepted within 100 cycles", b);
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic wait_drain(input string name);
    for (int t = 0; t < 200; t++) begin
      if (exp_q.size() == 0) return;
      @(posedge clk); #2;
    end
    checks++;
    errors++;
    $display("FAIL %s_timeout: %0d results still pending, required 0", name, exp_q.size());
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    out_ready = 1'b1;

    add_vec("12.5\r",     12, 50, 1'b0);
    add_vec(" 7\n",        7,  0, 1'b0);
    add_vec(".25\n",       0, 25, 1'b0);
    add_vec("4096\n",      0,  0, 1'b1);
    add_vec("5\n",         5,  0, 1'b0);
    add_vec("12345\n",     0,  0, 1'b1);
    add_vec("5\n",         5,  0, 1'b0);
    add_vec("1a2\n",       0,  0, 1'b1);
    add_vec("5\n",         5,  0, 1'b0);
    add_vec("3..1\n",      0,  0, 1'b1);
    add_vec("5\n",         5,  0, 1'b0);
    add_vec(".\n",         0,  0, 1'b1);
    add_vec("5\n",         5,  0, 1'b0);
    add_vec("1 2\n",       0,  0, 1'b1);
    add_vec("\n42.07\n",  42,  7, 1'b0);
    add_vec("99.9\n",     99, 90, 1'b0);
    add_vec("0.01\n",      0,  1, 1'b0);
`ifdef A2B_ROUND_EN
    add_vec("1.995\n",     2,  0, 1'b0);
    add_vec("2.555\n",     2, 56, 1'b0);
    add_vec("4095.999\n",  0,  0, 1'b1);
`else
    add_vec("1.995\n",     1, 99, 1'b0);
    add_vec("2.555\n",     2, 55, 1'b0);
    add_vec("4095.999\n", 4095, 99, 1'b0);
`endif

    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    #2;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_int",       int'(int_part), 0);
    chk("rst_dec",       int'(dec_part), 0);
    chk("rst_err",       int'(out_err), 0);
    chk("rst_in_ready",  int'(in_ready), 1);
    rst_n = 1'b1;
    @(posedge clk); #2;

    // One-cycle result latency and single-cycle out_valid.
    push_exp("lat", 4095, 99, 1'b0);
    send_str("4095.99");
    send_byte(8'h0A);
    chk("lat_edge_n_valid",   int'(out_valid), 0);
    @(posedge clk); #2;
    chk("lat_edge_n1_valid",  int'(out_valid), 1);
    chk("lat_edge_n1_ready",  int'(in_ready), 0);
    @(posedge clk); #2;
    chk("lat_edge_n2_valid",  int'(out_valid), 0);
    chk("lat_edge_n2_ready",  int'(in_ready), 1);
    wait_drain("lat");

    foreach (vecs[i]) begin
      push_exp($sformatf("vec%0d", i), vecs[i].ei, vecs[i].ed, vecs[i].ee);
      send_str(vecs[i].s);
      wait_drain($sformatf("vec%0d", i));
    end

    // Back-pressure: result held, offered byte not consumed.
    out_ready = 1'b0;
    push_exp("bp", 8, 8, 1'b0);
    send_str("8.08\n");
    for (int t = 0; t < 20; t++) begin
      if (out_valid) break;
      @(posedge clk); #2;
    end
    chk("bp_valid", int'(out_valid), 1);
    in_valid = 1'b1;
    in_byte  = 8'h39;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #2;
      chk("bp_hold_valid", int'(out_valid), 1);
      chk("bp_hold_int",   int'(int_part), 8);
      chk("bp_hold_dec",   int'(dec_part), 8);
      chk("bp_hold_ready", int'(in_ready), 0);
    end
    push_exp("bp_next", 9, 0, 1'b0);
    out_ready = 1'b1;
    send_byte(8'h39);
    send_byte(8'h0A);
    wait_drain("bp");

    // Asynchronous reset mid-number discards the partial value.
    send_str("12");
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_int",   int'(int_part), 0);
    chk("midrst_dec",   int'(dec_part), 0);
    chk("midrst_err",   int'(out_err), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    push_exp("rst_next", 3, 0, 1'b0);
    send_str("3\n");
    wait_drain("rst_next");

    repeat (5) @(posedge clk);
    #2;
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_out_valid",   int'(out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ascii_to_binary.md
Name: ascii_to_binary

Overview:
- Byte-serial ASCII decimal parser. It is the receive-side inverse of the binary-to-ASCII formatter.
- Accepts a character stream such as "4095.99\n" from the UART or host path and produces the binary integer part and the two-digit decimal part.
- Output format matches the formatter's inputs (12-bit integer, 8-bit decimal 0..99), so a formatter-to-parser loopback is bit-exact.

Parameters:
- INT_W, 12, integer result width; maximum accepted value is 2^INT_W-1.
- DEC_W, 8, decimal result width; holds 0..99.
- INT_DIGITS, 4, maximum integer digits accepted.
- DEC_DIGITS, 2, decimal digits kept.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_byte is valid
- in_byte  input  8  ASCII character
- in_ready  output  1  byte accepted when in_valid && in_ready
- int_part  output  INT_W  parsed integer part
- dec_part  output  DEC_W  parsed decimal part, 0..99
- out_err  output  1  result is a parse error; qualified by out_valid
- out_valid  output  1  result available, held until accepted
- out_ready  input  1  consumer accepts the result

Behaviour:
- Reset: clk and rst_n as above; rst_n is asynchronous, active-low.
  - All outputs are 0 and the state is IDLE.
  - Asserting rst_n mid-number discards the partial result with no out_valid.
- Character classes:
  - digit: 0x30..0x39
  - point: 0x2E
  - terminator: 0x0A or 0x0D
  - space: 0x20
  - anything else is illegal.
- States: IDLE, INT, DEC, ERR, DONE. in_ready=1 in every state except DONE.
- IDLE:
  - space is ignored.
  - digit: acc=d, go to INT.
  - point: go to DEC with zero integer digits.
  - terminator: ignored (empty line).
  - illegal: go to ERR.
- INT:
  - digit: acc=acc*10+d. Going to ERR if the digit count exceeds INT_DIGITS or acc exceeds 2^INT_W-1.
  - point: go to DEC.
  - terminator: go to DONE.
  - space or illegal: go to ERR.
- DEC:
  - 1st digit: frac=d*10.
  - 2nd digit: frac+=d.
  - Further digits are dropped; see the optional feature for rounding.
  - terminator: go to DONE.
    - If zero integer digits and zero decimal digits were seen (a bare "."), go to ERR, which terminates immediately to DONE with error.
  - point, space or illegal: go to ERR.
  - One decimal digit yields d*10, e.g. ".5" gives 50.
- ERR: consume bytes until a terminator, then go to DONE with out_err=1.
- DONE:
  - out_valid=1; int_part/dec_part are registered.
  - On error, int_part=0, dec_part=0, out_err=1.
  - Outputs are held stable while out_valid && !out_ready.
  - On out_valid && out_ready: out_valid drops next cycle, state returns to IDLE, and in_ready rises in that same cycle.
- Latency: terminator accepted on edge N gives out_valid=1 after edge N+1 (one cycle).
- Multiply by 10 is done as (acc<<3)+(acc<<1) in INT_W+4 bits; overflow is checked on the wide value before truncation.

Optional Feature:
- Macro: A2B_ROUND_EN.
- Defined:
  - The third decimal digit is kept; if it is >=5, the decimal part is incremented at terminator.
  - 99 rounds to 0 with a carry into the integer part.
  - A carry past 2^INT_W-1 sets out_err.
  - Result latency stays one cycle; the round is performed in the DONE-entry transition.
- Not defined: decimal digits beyond DEC_DIGITS are truncated; no rounding logic is present.

Decomposition:
- Package a2b_pkg:
  - state enum a2b_state_t (IDLE, INT, DEC, ERR, DONE)
  - ASCII constants ASCII_0, ASCII_9, ASCII_POINT, ASCII_LF, ASCII_CR, ASCII_SPACE
  - char-class enum (DIGIT, POINT, TERM, SPACE, ILLEGAL)
- Sub-module ascii_char_class (combinational): in_byte in, class and 4-bit digit value out.
- The FSM, accumulators and output registers live in ascii_to_binary.

Test Plan:
- "4095.99\n" with out_ready=1: int_part=0xFFF, dec_part=0x63, out_err=0, out_valid for one cycle, one cycle after LF.
- "12.5\r" gives int=12, dec=50. " 7\n" (leading space) gives int=7, dec=0. ".25\n" gives int=0, dec=25.
- Each of "4096\n", "12345\n", "1a2\n", "3..1\n", ".\n" gives out_err=1 with int=0, dec=0. A following "5\n" then parses cleanly to int=5.
- Back-pressure: "8.08\n" with out_ready=0 for 5 cycles: out_valid and outputs stay stable, in_ready=0, and any bytes offered are not consumed. After out_ready=1, the next number parses normally.
- Reset: pull rst_n low after "12" is accepted. All outputs go to 0 immediately; the following "3\n" gives int=3.
- "1.995\n" gives int=1, dec=99 without A2B_ROUND_EN and int=2, dec=0 with it. "4095.999\n" with A2B_ROUND_EN gives out_err=1.
